// File: rtl/vesa_pkg.sv
// Shared VESA mode constants and helpers for the parametrised timing generator.
// Each mode is described per axis as visible/front/sync/back lengths.
package vesa_pkg;

  typedef struct packed {
    int unsigned visible;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_mode_t;

  localparam axis_mode_t MODE_1280X1024_60_H = '{1280, 48, 112, 248};
  localparam axis_mode_t MODE_1280X1024_60_V = '{1024, 1, 3, 38};
  localparam axis_mode_t MODE_1024X768_60_H  = '{1024, 24, 136, 160};
  localparam axis_mode_t MODE_1024X768_60_V  = '{768, 3, 6, 29};
  localparam axis_mode_t MODE_640X480_60_H   = '{640, 16, 96, 48};
  localparam axis_mode_t MODE_640X480_60_V   = '{480, 10, 2, 33};

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vesa_timing_gen_if.sv
// Video timing bundle between the sync generator (master) and the pixel source (slave).
// The pixel clock-enable travels with the bundle so both sides agree on the pixel rate.
interface vesa_timing_gen_if #(
  parameter int CW = 11
);
  logic          ce;
  logic          vga_h_sync;
  logic          vga_v_sync;
  logic          inDisplayArea;
  logic [CW-1:0] CounterX;
  logic [CW-1:0] CounterY;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  ce,
    output vga_h_sync, vga_v_sync, inDisplayArea,
    output CounterX, CounterY, pixel_x, pixel_y,
    output line_start, frame_start
  );

  modport slave (
    output ce,
    input  vga_h_sync, vga_v_sync, inDisplayArea,
    input  CounterX, CounterY, pixel_x, pixel_y,
    input  line_start, frame_start
  );
endinterface

// File: rtl/timing_axis_cnt.sv
// Wrap counter for one video axis, with combinational sync and active window flags
// decoded from the current count (the caller registers them).
module timing_axis_cnt #(
  parameter int CW         = 11,
  parameter int TOTAL      = 1688,
  parameter int SYNC_START = 1344,
  parameter int SYNC_LEN   = 112,
  parameter int ACT_START  = 16,
  parameter int ACT_LEN    = 1280
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic          in_sync,
  output logic          in_act
);

  localparam logic [CW-1:0] LAST_VAL = CW'(TOTAL - 1);

  if ((TOTAL - 1) >= (1 << CW)) begin : g_width_err
    $error("timing_axis_cnt: TOTAL-1 = %0d does not fit in %0d bits", TOTAL - 1, CW);
  end

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= last ? '0 : cnt_reg + CW'(1);
    end
  end

  assign cnt     = cnt_reg;
  assign last    = (cnt_reg == LAST_VAL);
  assign in_sync = (int'(cnt_reg) >= SYNC_START) && (int'(cnt_reg) < SYNC_START + SYNC_LEN);
  assign in_act  = (int'(cnt_reg) >= ACT_START) && (int'(cnt_reg) < ACT_START + ACT_LEN);

endmodule

// File: rtl/vesa_timing_gen.sv
// Parametrised VESA sync generator: horizontal/vertical axis counters plus
// registered syncs, display enable, pixel coordinates and line/frame strobes.
module vesa_timing_gen
  import vesa_pkg::*;
#(
  parameter int CW        = 11,
  parameter int H_VISIBLE = 1280,
  parameter int H_FRONT   = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BACK    = 248,
  parameter int V_VISIBLE = 1024,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 38,
  parameter bit H_POL     = 1'b1,
  parameter bit V_POL     = 1'b1,
  parameter int LEAD      = 16
) (
  input  logic               clk,
  input  logic               rst,
  vesa_timing_gen_if.master  vid
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int HS0     = LEAD + H_VISIBLE + H_FRONT;
  localparam int VS0     = V_VISIBLE + V_FRONT;
  localparam logic [CW-1:0] LEAD_C = CW'(LEAD);

  if (LEAD >= H_FRONT + H_SYNC + H_BACK) begin : g_lead_err
    $error("vesa_timing_gen: LEAD = %0d must be below the horizontal blanking length", LEAD);
  end

  logic [CW-1:0] hc, vc;
  logic          h_last, h_in_sync, h_in_act;
  logic          v_last, v_in_sync, v_in_act;

  timing_axis_cnt #(
    .CW(CW), .TOTAL(H_TOTAL), .SYNC_START(HS0), .SYNC_LEN(H_SYNC),
    .ACT_START(LEAD), .ACT_LEN(H_VISIBLE)
  ) u_h_axis (
    .clk(clk), .rst(rst), .en(vid.ce),
    .cnt(hc), .last(h_last), .in_sync(h_in_sync), .in_act(h_in_act)
  );

  // The vertical axis steps once per line, on the clock where hc wraps.
  timing_axis_cnt #(
    .CW(CW), .TOTAL(V_TOTAL), .SYNC_START(VS0), .SYNC_LEN(V_SYNC),
    .ACT_START(0), .ACT_LEN(V_VISIBLE)
  ) u_v_axis (
    .clk(clk), .rst(rst), .en(vid.ce & h_last),
    .cnt(vc), .last(v_last), .in_sync(v_in_sync), .in_act(v_in_act)
  );

  logic          active;
  logic          h_sync_reg, h_sync_next;
  logic          v_sync_reg, v_sync_next;
  logic          de_reg;
  logic [CW-1:0] pixel_x_reg, pixel_x_next;
  logic [CW-1:0] pixel_y_reg, pixel_y_next;
  logic          line_start_reg, line_start_next;
  logic          frame_start_reg, frame_start_next;

  always_comb begin
    active           = h_in_act && v_in_act;
    h_sync_next      = h_in_sync ? H_POL : ~H_POL;
    v_sync_next      = v_in_sync ? V_POL : ~V_POL;
    pixel_x_next     = active ? hc - LEAD_C : '0;
    pixel_y_next     = active ? vc : '0;
    line_start_next  = vid.ce && (hc == '0);
    frame_start_next = line_start_next && (vc == '0);
  end

  // Strobes are rewritten every clock so they drop while ce is low; the rest hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sync_reg      <= ~H_POL;
      v_sync_reg      <= ~V_POL;
      de_reg          <= 1'b0;
      pixel_x_reg     <= '0;
      pixel_y_reg     <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      if (vid.ce) begin
        h_sync_reg  <= h_sync_next;
        v_sync_reg  <= v_sync_next;
        de_reg      <= active;
        pixel_x_reg <= pixel_x_next;
        pixel_y_reg <= pixel_y_next;
      end
    end
  end

  assign vid.vga_h_sync    = h_sync_reg;
  assign vid.vga_v_sync    = v_sync_reg;
  assign vid.inDisplayArea = de_reg;
  assign vid.CounterX      = hc;
  assign vid.CounterY      = vc;
  assign vid.pixel_x       = pixel_x_reg;
  assign vid.pixel_y       = pixel_y_reg;
  assign vid.line_start    = line_start_reg;
  assign vid.frame_start   = frame_start_reg;

endmodule

// File: tb/tb_vesa_timing_gen.sv
// Directed bench: default 1280x1024 mode (line timing, mid-line reset) and a
// 16x8 toy mode with positive/negative polarity and a half-rate clock-enable.
module tb_vesa_timing_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_s = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vesa_timing_gen_if #(.CW(11)) bus_a ();
  vesa_timing_gen_if #(.CW(5))  bus_b ();
  vesa_timing_gen_if #(.CW(5))  bus_c ();

  vesa_timing_gen dut_a (.clk(clk), .rst(rst_a), .vid(bus_a));

  vesa_timing_gen #(
    .CW(5), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .LEAD(2)
  ) dut_b (.clk(clk), .rst(rst_s), .vid(bus_b));

  vesa_timing_gen #(
    .CW(5), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1'b0), .V_POL(1'b0), .LEAD(2)
  ) dut_c (.clk(clk), .rst(rst_s), .vid(bus_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Toy mode after 'adv' enabled edges: H 16 clocks (window hc 2..9, sync 12..14),
  // V 8 lines (active 0..3, sync 5..6). Packed as {hs,vs,de,ls,fs,cx,cy,px,py}.
  function automatic logic [24:0] small_exp(input int adv, input bit pol, input bit strobes_on);
    int hp, vp;
    logic hs, vs, de, ls, fs;
    logic [4:0] cx, cy, px, py;
    hp = (adv - 1) % 16;
    vp = ((adv - 1) / 16) % 8;
    hs = (hp >= 12 && hp <= 14) ? pol : ~pol;
    vs = (vp >= 5 && vp <= 6) ? pol : ~pol;
    de = (hp >= 2 && hp <= 9 && vp <= 3);
    ls = strobes_on && (hp == 0);
    fs = strobes_on && (hp == 0) && (vp == 0);
    cx = 5'(adv % 16);
    cy = 5'((adv / 16) % 8);
    px = de ? 5'(hp - 2) : 5'd0;
    py = de ? 5'(vp) : 5'd0;
    return {hs, vs, de, ls, fs, cx, cy, px, py};
  endfunction

  function automatic logic [24:0] small_got(input logic hs, vs, de, ls, fs,
                                            input logic [4:0] cx, cy, px, py);
    return {hs, vs, de, ls, fs, cx, cy, px, py};
  endfunction

  initial begin
    int   rise1, rise2, hs_high, vs_high, de_cnt, de_tot, first_de;
    int   px_bad, px_nxt, ls_cnt, fs_cnt, wait_n, adv;
    logic hs_prev;

    bus_a.ce = 1'b1;
    bus_b.ce = 1'b1;
    bus_c.ce = 1'b1;
    repeat (3) tick();

    // Reset state, including inverted-polarity idle levels
    check("a_rst_hs", 32'(bus_a.vga_h_sync), 32'd0);
    check("a_rst_vs", 32'(bus_a.vga_v_sync), 32'd0);
    check("a_rst_de", 32'(bus_a.inDisplayArea), 32'd0);
    check("a_rst_cx", 32'(bus_a.CounterX), 32'd0);
    check("a_rst_ls", 32'(bus_a.line_start), 32'd0);
    check("c_rst_hs", 32'(bus_c.vga_h_sync), 32'd1);
    check("c_rst_vs", 32'(bus_c.vga_v_sync), 32'd1);
    check("b_rst_hs", 32'(bus_b.vga_h_sync), 32'd0);

    // Default mode: two full lines
    rst_a = 1'b0;
    hs_prev = 1'b0;
    rise1 = 0; rise2 = 0; hs_high = 0; vs_high = 0; de_cnt = 0; de_tot = 0;
    first_de = 0; px_bad = 0; px_nxt = 0; ls_cnt = 0; fs_cnt = 0;
    for (int k = 1; k <= 3377; k++) begin
      tick();
      if (k == 1) begin
        check("a_first_cx", 32'(bus_a.CounterX), 32'd1);
        check("a_first_ls", 32'(bus_a.line_start), 32'd1);
        check("a_first_fs", 32'(bus_a.frame_start), 32'd1);
      end
      if (!hs_prev && bus_a.vga_h_sync) begin
        if (rise1 == 0) rise1 = k;
        else if (rise2 == 0) rise2 = k;
      end
      hs_prev = bus_a.vga_h_sync;
      if (k >= 1345 && k <= 3032 && bus_a.vga_h_sync) hs_high++;
      if (bus_a.vga_v_sync) vs_high++;
      if (bus_a.inDisplayArea) begin
        de_tot++;
        if (k <= 1688) begin
          de_cnt++;
          if (first_de == 0) first_de = k;
        end
        if (int'(bus_a.pixel_x) != px_nxt || int'(bus_a.pixel_y) != (k - 1) / 1688) px_bad++;
        px_nxt = (px_nxt == 1279) ? 0 : px_nxt + 1;
      end
      ls_cnt += int'(bus_a.line_start);
      fs_cnt += int'(bus_a.frame_start);
      if (k == 1688) begin
        check("a_wrap_cx", 32'(bus_a.CounterX), 32'd0);
        check("a_wrap_cy", 32'(bus_a.CounterY), 32'd1);
      end
    end
    check("a_hs_rise1", 32'(rise1), 32'd1345);
    check("a_hs_rise2", 32'(rise2), 32'd3033);
    check("a_hs_width", 32'(hs_high), 32'd112);
    check("a_vs_idle", 32'(vs_high), 32'd0);
    check("a_de_line0", 32'(de_cnt), 32'd1280);
    check("a_de_total", 32'(de_tot), 32'd2560);
    check("a_first_de", 32'(first_de), 32'd17);
    check("a_px_seq_bad", 32'(px_bad), 32'd0);
    check("a_ls_count", 32'(ls_cnt), 32'd3);
    check("a_fs_count", 32'(fs_cnt), 32'd1);

    // Mid-line asynchronous reset at hc=700
    wait_n = 0;
    while (bus_a.CounterX != 11'd700 && wait_n < 2000) begin
      tick();
      wait_n++;
    end
    check("a_reach_700", 32'(bus_a.CounterX), 32'd700);
    check("a_de_700", 32'(bus_a.inDisplayArea), 32'd1);
    check("a_px_700", 32'(bus_a.pixel_x), 32'd683);
    check("a_cy_700", 32'(bus_a.CounterY), 32'd2);
    rst_a = 1'b1;
    #1;
    check("a_arst_cx", 32'(bus_a.CounterX), 32'd0);
    check("a_arst_cy", 32'(bus_a.CounterY), 32'd0);
    check("a_arst_de", 32'(bus_a.inDisplayArea), 32'd0);
    check("a_arst_px", 32'(bus_a.pixel_x), 32'd0);
    repeat (3) tick();
    check("a_hold_cx", 32'(bus_a.CounterX), 32'd0);
    check("a_hold_ls", 32'(bus_a.line_start), 32'd0);
    rst_a = 1'b0;
    tick();
    check("a_rel_cx", 32'(bus_a.CounterX), 32'd1);
    check("a_rel_ls", 32'(bus_a.line_start), 32'd1);
    check("a_rel_fs", 32'(bus_a.frame_start), 32'd1);
    tick();
    check("a_rel2_cx", 32'(bus_a.CounterX), 32'd2);
    check("a_rel2_ls", 32'(bus_a.line_start), 32'd0);

    // Toy modes: C at full rate with negative syncs, B with ce on every other clock
    rst_s = 1'b0;
    bus_b.ce = 1'b1;
    for (int j = 1; j <= 260; j++) begin
      tick();
      check($sformatf("c_j%0d", j),
            32'(small_got(bus_c.vga_h_sync, bus_c.vga_v_sync, bus_c.inDisplayArea,
                          bus_c.line_start, bus_c.frame_start, bus_c.CounterX,
                          bus_c.CounterY, bus_c.pixel_x, bus_c.pixel_y)),
            32'(small_exp(j, 1'b0, 1'b1)));
      adv = (j + 1) / 2;
      check($sformatf("b_j%0d", j),
            32'(small_got(bus_b.vga_h_sync, bus_b.vga_v_sync, bus_b.inDisplayArea,
                          bus_b.line_start, bus_b.frame_start, bus_b.CounterX,
                          bus_b.CounterY, bus_b.pixel_x, bus_b.pixel_y)),
            32'(small_exp(adv, 1'b1, (j % 2) == 1)));
      bus_b.ce = ((j % 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
